// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_scan_pkg;

  typedef enum logic {BLANK, SHOW} scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // All-ones anode mask for the given digit count (1..8), right-aligned.
  function automatic logic [7:0] an_off(int unsigned digits);
    an_off = 8'((16'd1 << digits) - 16'd1);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: counts one digit slot and sequences the BLANK/SHOW phases.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic show_start,
  output logic slot_end,
  output logic showing
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    show_start = enable && (state_q == BLANK) && (cnt_q == BLANK_LAST);
    slot_end   = enable && (state_q == SHOW) && (cnt_q == SLOT_LAST);
    showing    = (state_q == SHOW);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (!enable) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        BLANK: if (show_start) state_d = SHOW;
        SHOW: begin
          if (slot_end) begin
            state_d = BLANK;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with blanking between digits.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [8*DIGITS-1:0]   seg_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_tick
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]     LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [7:0]        AN_OFF_ALL = an_off(DIGITS);
  localparam logic [DIGITS-1:0] AN_OFF     = AN_OFF_ALL[DIGITS-1:0];

  logic show_start, slot_end, showing;

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .show_start (show_start),
    .slot_end   (slot_end),
    .showing    (showing)
  );

  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        snap_q, snap_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              tick_q, tick_d;
  logic [7:0]        cur_pat;
  logic [DIGITS-1:0] an_sel;

  assign cur_pat = seg_in[{idx_q, 3'b000} +: 8];
  assign an_sel  = ~(DIGITS'(1) << idx_q);

  // Output flops are loaded from next-state so they switch on the same edge as the phase.
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    seg_d  = SEG_OFF;
    an_d   = AN_OFF;
    tick_d = 1'b0;
    if (!enable) begin
      idx_d = '0;
    end else begin
      if (show_start) begin
        snap_d = cur_pat;
        seg_d  = cur_pat;
        an_d   = an_sel;
      end else if (showing && !slot_end) begin
        seg_d = snap_q;
        an_d  = an_sel;
      end
      if (slot_end) begin
        idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        tick_d = (idx_q == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      snap_q <= SEG_OFF;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      tick_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux against a time-based reference model.
module tb_seg_scan_mux;

  localparam int unsigned DIGITS       = 8;
  localparam int unsigned SCAN_DIV     = 10;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned FRAME        = DIGITS * SCAN_DIV;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [8*DIGITS-1:0] seg_in = '1;
  logic [7:0]          seg_out;
  logic [DIGITS-1:0]   an_out;
  logic                frame_tick;

  seg_scan_mux #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;
    logic              tick;
  } resp_t;

  resp_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;

  // Model: t = enabled edges since last reset/disable; everything follows from t.
  int         t = 0;
  logic [7:0] snap_m = 8'hFF;
  bit         armed = 1'b0;

  always @(posedge clock) begin : model
    resp_t r;
    int    phase, digit;
    cycle++;
    r.seg  = 8'hFF;
    r.an   = '1;
    r.tick = 1'b0;
    if (reset || !enable) begin
      t = 0;
      if (reset) armed = 1'b1;
    end else if (armed) begin
      t++;
      phase = t % SCAN_DIV;
      digit = (t / SCAN_DIV) % DIGITS;
      if (phase == BLANK_CYCLES) snap_m = seg_in[digit*8 +: 8];
      if (phase >= BLANK_CYCLES) begin
        r.seg = snap_m;
        r.an  = ~(DIGITS'(1) << digit);
      end
      r.tick = ((t % FRAME) == 0);
    end
    if (armed) exp_q.push_back(r);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, req);
    end
  endtask

  always @(negedge clock) begin : monitor
    resp_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("seg_out", 32'(seg_out), 32'(r.seg));
      check("an_out", 32'(an_out), 32'(r.an));
      check("frame_tick", 32'(frame_tick), 32'(r.tick));
      if (an_out !== '1) check("an_onehot", 32'($countones(~an_out)), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    seg_in         = {$urandom, $urandom};
    seg_in[7:0]    = 8'h01;
    seg_in[15:8]   = 8'h4F;
    seg_in[23:16]  = 8'h12;
    enable         = 1'b1;
    reset          = 1'b1;
    step(3);
    reset = 1'b0;
    // Digit 2 shows from t=22; cycle 4 of its show phase is t=25.
    step(25);
    seg_in[23:16] = 8'h06;
    step(3 * FRAME);
    // t=265 (digit 2); advance to t=295, inside digit 5's show phase.
    step(30);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    // Digit 3 shows from t=32.
    step(35);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(FRAME + 20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) seg_in[$urandom_range(0, DIGITS-1)*8 +: 8] = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        step($urandom_range(1, 5));
        enable = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end else begin
        step(1);
      end
    end

    @(negedge clock);
    #1;
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL vector_count: got %0d, expected at least 12", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexing driver for a physical common-anode seven-segment display, downstream of the GPIO APB peripheral's eight per-digit segment outputs.
- Accepts up to eight 8-bit active-low segment patterns (bit 7 = dp, bits 6..0 = a..g, 0 = lit).
- Scans them one digit at a time onto a shared segment bus with a one-hot active-low anode select.
- Inserts a blanking interval before each digit to suppress ghosting.
- Flags each completed frame.

## Interface
Parameters:
- DIGITS, 8: digits scanned, legal 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot (blank + show), must exceed BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at slot start with all segments and anodes off, ≥1.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  scan enable; 0 forces display dark and restarts scan.
- seg_in  in  8*DIGITS  digit i pattern at [8i+7:8i], active-low, passed through unmodified.
- seg_out  out  8  shared segment bus, active-low.
- an_out  out  DIGITS  anode select, active-low one-hot.
- frame_tick  out  1  one-cycle pulse when scan wraps from digit DIGITS-1 to 0.

## Operation
- Registers: state {BLANK, SHOW}, slot counter cnt (width $clog2(SCAN_DIV)), digit index idx (width max(1,$clog2(DIGITS))), pattern snapshot snap[7:0].
- BLANK: cnt counts 0..BLANK_CYCLES-1.
  - Outputs: seg_out=8'hFF, an_out all ones.
  - At cnt==BLANK_CYCLES-1: go SHOW, cnt++, snap<=seg_in[8*idx+:8].
- SHOW: cnt counts BLANK_CYCLES..SCAN_DIV-1.
  - Outputs: seg_out=snap, an_out=~(1<<idx).
  - At cnt==SCAN_DIV-1: go BLANK, cnt<=0, idx<=(idx==DIGITS-1)?0:idx+1.
  - frame_tick=1 on that same edge when idx wraps to 0.
- Snapshot rule: seg_in is sampled only on the BLANK→SHOW edge. Changes during SHOW do not appear until that digit's next slot, so no tearing.
- enable=0 on any edge: state<=BLANK, cnt<=0, idx<=0, outputs dark, frame_tick=0.
  - Re-assertion restarts at digit 0 with a full blank interval.
- DIGITS=1: idx stays 0; frame_tick pulses at every slot end.
- No combinational path from seg_in or enable to any output.

## Timing
- All outputs are registered and change only on clock edges, on the same edge as the state transition they reflect.
- Reset values (applied on the first edge with reset=1): state=BLANK, cnt=0, idx=0, snap=8'hFF, seg_out=8'hFF, an_out={DIGITS{1'b1}}, frame_tick=0.
- Reset mid-operation: outputs go dark on the next edge regardless of state. Reset dominates enable.
- Slot length exactly SCAN_DIV cycles: BLANK_CYCLES dark, SCAN_DIV-BLANK_CYCLES lit. Frame = DIGITS*SCAN_DIV cycles.
- First lit cycle after reset release (enable=1 throughout): the edge ending cycle BLANK_CYCLES-1 counted from the first non-reset edge.
- An anode is never low while seg_out carries the previous digit's pattern: anode and segment flops update on the same edge, with a blank gap between digits.

## Structure
- Shared package seg_scan_pkg holds:
  - state enum {BLANK, SHOW};
  - SEG_OFF=8'hFF;
  - AN_OFF (all-ones helper function of DIGITS).
- One sub-module, seg_scan_timer: slot counter plus BLANK/SHOW state. It emits show_start and slot_end strobes.
- Top level owns idx, snap, output flops and frame_tick.

## Test plan
Parameters: DIGITS=8, SCAN_DIV=10, BLANK_CYCLES=2.
- Reset held 3 cycles → seg_out=8'hFF, an_out=8'hFF, frame_tick=0 on every cycle.
- seg_in digit0=8'h01, digit1=8'h4F, enable=1, release reset:
  - 2 dark cycles;
  - then an_out=8'hFE, seg_out=8'h01 for 8 cycles;
  - then 2 dark;
  - then an_out=8'hFD, seg_out=8'h4F.
- Run 3 frames → frame_tick high exactly 1 cycle every 80 cycles, coincident with the digit7→digit0 transition. an_out never has two zero bits.
- Change digit2 from 8'h12 to 8'h06 on cycle 4 of digit 2's show phase → seg_out stays 8'h12 for the rest of that slot and shows 8'h06 on the next frame.
- Drop enable during digit 5's show phase → next edge dark, idx=0. Re-assert → 2 dark cycles, then an_out=8'hFE.
- Assert reset during digit 3's show phase → next edge all reset values. Scan restarts at digit 0 after release.
